// File: rtl/meas_fifo_pkg.sv
// Shared constants and helpers for the measurement word FIFO and its byte serializer.
package meas_fifo_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] RD_EMPTY_BYTE = 8'h00;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/meas_fifo_ram.sv
// Word FIFO storage with wrap-around pointers and an exact level counter.
// Head word is read combinationally; the caller never pushes when full or pops when empty.
module meas_fifo_ram
  import meas_fifo_pkg::*;
#(
  parameter int BYTE_NUM = 3,
  parameter int DEPTH    = 16,
  localparam int WORD_W  = BYTE_W * BYTE_NUM,
  localparam int PTR_W   = clog2(DEPTH),
  localparam int LVL_W   = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wr_data,
  output logic [WORD_W-1:0] head_word,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head_word = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);

endmodule

// File: rtl/meas_word_serializer.sv
// Measurement FIFO streamed out one byte per rd_req, 1-cycle registered latency.
// Writes while full are dropped (sticky overflow) unless a word pops that cycle; empty reads return 00 (sticky underflow).
module meas_word_serializer
  import meas_fifo_pkg::*;
#(
  parameter int BYTE_NUM = 3,
  parameter int DEPTH    = 16,
  localparam int LVL_W   = clog2(DEPTH) + 1
) (
  input  logic                       clk_12mhz,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [BYTE_W*BYTE_NUM-1:0] wr_data,
  input  logic                       rd_req,
  input  logic                       xfer_done,
  input  logic                       msb_first,
  input  logic                       keep_partial,
  input  logic                       clr_flags,
  output logic [BYTE_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [LVL_W-1:0]           level,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int WORD_W = BYTE_W * BYTE_NUM;
  localparam int IDX_W  = (BYTE_NUM > 1) ? clog2(BYTE_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_NUM - 1);

  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d, byte_sel;
  logic              order_q, order_d, eff_msb;
  logic [BYTE_W-1:0] rd_data_q, rd_data_d, head_byte;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push, pop, ovf_set, unf_set;
  logic              ram_full, ram_empty;
  logic [WORD_W-1:0] head_word;

  meas_fifo_ram #(
    .BYTE_NUM (BYTE_NUM),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk       (clk_12mhz),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .wr_data   (wr_data),
    .head_word (head_word),
    .level     (level),
    .full      (ram_full),
    .empty     (ram_empty)
  );

  // The order input is only sampled on the first byte of a word; later bytes use the latch.
  always_comb begin
    eff_msb   = (byte_idx_q == '0) ? msb_first : order_q;
    byte_sel  = eff_msb ? (LAST_IDX - byte_idx_q) : byte_idx_q;
    head_byte = '0;
    for (int k = 0; k < BYTE_NUM; k++) begin
      if (byte_sel == IDX_W'(k)) head_byte = head_word[BYTE_W*k +: BYTE_W];
    end
  end

  always_comb begin
    byte_idx_d = byte_idx_q;
    order_d    = order_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    pop        = 1'b0;
    unf_set    = 1'b0;
    // An abort swallows any rd_req of the same cycle.
    if (xfer_done) begin
      if (byte_idx_q != '0) begin
        byte_idx_d = '0;
        pop        = !keep_partial;
      end
    end else if (rd_req) begin
      rd_valid_d = 1'b1;
      if (ram_empty) begin
        rd_data_d = RD_EMPTY_BYTE;
        unf_set   = 1'b1;
      end else begin
        rd_data_d = head_byte;
        order_d   = eff_msb;
        if (byte_idx_q == LAST_IDX) begin
          byte_idx_d = '0;
          pop        = 1'b1;
        end else begin
          byte_idx_d = byte_idx_q + IDX_W'(1);
        end
      end
    end
    // A pop frees a slot in the same cycle, so a write into a full FIFO is still taken.
    push        = wr_en && (!ram_full || pop);
    ovf_set     = wr_en && ram_full && !pop;
    overflow_d  = ovf_set || (overflow_q && !clr_flags);
    underflow_d = unf_set || (underflow_q && !clr_flags);
  end

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q  <= '0;
      order_q     <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      order_q     <= order_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign empty     = ram_empty;
  assign full      = ram_full;

endmodule

// File: tb/tb_meas_word_serializer.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_meas_word_serializer;

  localparam int BN = 3;
  localparam int DP = 4;

  logic        clk_12mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [23:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic        xfer_done = 1'b0;
  logic        msb_first = 1'b0;
  logic        keep_partial = 1'b0;
  logic        clr_flags = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [2:0]  level;
  logic        empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  meas_word_serializer #(.BYTE_NUM(BN), .DEPTH(DP)) dut (
    .clk_12mhz    (clk_12mhz),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .xfer_done    (xfer_done),
    .msb_first    (msb_first),
    .keep_partial (keep_partial),
    .clr_flags    (clr_flags),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  // Reference model: a queue of whole words plus the position inside the head word.
  logic [23:0] m_q[$];
  int          m_idx;
  logic        m_order;
  logic        m_ovf, m_unf, m_vld;
  logic [7:0]  m_dat;

  task automatic model_reset();
    m_q.delete();
    m_idx = 0; m_order = 0; m_ovf = 0; m_unf = 0; m_vld = 0; m_dat = 8'h00;
  endtask

  task automatic model_step();
    bit pop, ovf_set, unf_set;
    int k;
    logic [23:0] w;
    pop = 0; ovf_set = 0; unf_set = 0; m_vld = 0;
    if (xfer_done) begin
      if (m_idx != 0) begin
        if (!keep_partial) pop = 1;
        m_idx = 0;
      end
    end else if (rd_req) begin
      m_vld = 1;
      if (m_q.size() == 0) begin
        m_dat = 8'h00;
        unf_set = 1;
      end else begin
        if (m_idx == 0) m_order = msb_first;
        w = m_q[0];
        k = m_order ? (BN - 1 - m_idx) : m_idx;
        m_dat = 8'(w >> (8 * k));
        m_idx++;
        if (m_idx == BN) begin m_idx = 0; pop = 1; end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (wr_en) begin
      if (m_q.size() < DP) m_q.push_back(wr_data);
      else ovf_set = 1;
    end
    m_ovf = ovf_set ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
    m_unf = unf_set ? 1'b1 : (clr_flags ? 1'b0 : m_unf);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_12mhz);
    #1;
    wr_en = 0; rd_req = 0; xfer_done = 0; clr_flags = 0;
  endtask

  task automatic push_word(input logic [23:0] w);
    wr_data = w; wr_en = 1; tick();
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    #12;
    checks++;
    if ({rd_data, rd_valid, level, empty, full, overflow, underflow} !== {8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: data=%h vld=%b lvl=%0d empty=%b full=%b ovf=%b unf=%b, required 00 0 0 1 0 0 0",
               rd_data, rd_valid, level, empty, full, overflow, underflow);
    end
    rst_n = 1;
    @(posedge clk_12mhz); #1;
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hC3; exp_b[1] = 8'hB2; exp_b[2] = 8'hA1;
    msb_first = 0;
    push_word(24'hA1B2C3);
    checks++;
    if (level !== 3'd1) begin errors++; $display("FAIL lsb_level_after_write: got %0d, required 1", level); end
    for (int i = 0; i < 3; i++) begin
      rd_req = 1; tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_b[i]) begin
        errors++; $display("FAIL lsb_byte%0d: vld=%b data=%h, required 1 %h", i, rd_valid, rd_data, exp_b[i]);
      end
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'hA1 || level !== 3'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL lsb_after: vld=%b data=%h lvl=%0d empty=%b, required 0 a1 0 1", rd_valid, rd_data, level, empty);
    end
  endtask

  task automatic test_order_latch();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
    push_word(24'hA1B2C3);
    msb_first = 1;
    for (int i = 0; i < 3; i++) begin
      rd_req = 1; tick();
      msb_first = 0;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_b[i]) begin
        errors++; $display("FAIL order_latch_byte%0d: vld=%b data=%h, required 1 %h", i, rd_valid, rd_data, exp_b[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] e;
    msb_first = 0;
    clr_flags = 1; tick();
    for (int i = 1; i <= 5; i++) push_word(24'(i));
    checks++;
    if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_state: lvl=%0d full=%b ovf=%b, required 4 1 1", level, full, overflow);
    end
    for (int i = 0; i < 12; i++) begin
      rd_req = 1; tick();
      e = (i % 3 == 0) ? 8'(i / 3 + 1) : 8'h00;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        errors++; $display("FAIL overflow_read%0d: vld=%b data=%h, required 1 %h", i, rd_valid, rd_data, e);
      end
    end
    checks++;
    if (empty !== 1'b1 || level !== 3'd0) begin
      errors++; $display("FAIL overflow_drained: empty=%b lvl=%0d, required 1 0", empty, level);
    end
    clr_flags = 1; tick();
  endtask

  task automatic test_abort_keep();
    logic [7:0] exp_b [6];
    exp_b = '{8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44};
    msb_first = 0;
    push_word(24'h112233);
    push_word(24'h445566);
    rd_req = 1; tick();
    checks++;
    if (rd_data !== 8'h33) begin errors++; $display("FAIL keep_first: data=%h, required 33", rd_data); end
    keep_partial = 1; xfer_done = 1; rd_req = 1; tick();
    checks++;
    if (rd_valid !== 1'b0 || level !== 3'd2) begin
      errors++; $display("FAIL keep_abort: vld=%b lvl=%0d, required 0 2", rd_valid, level);
    end
    for (int i = 0; i < 6; i++) begin
      rd_req = 1; tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_b[i]) begin
        errors++; $display("FAIL keep_read%0d: vld=%b data=%h, required 1 %h", i, rd_valid, rd_data, exp_b[i]);
      end
    end
  endtask

  task automatic test_abort_discard();
    msb_first = 0;
    push_word(24'h112233);
    push_word(24'h445566);
    rd_req = 1; tick();
    keep_partial = 0; xfer_done = 1; tick();
    checks++;
    if (level !== 3'd1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL discard_level: lvl=%0d vld=%b, required 1 0", level, rd_valid);
    end
    rd_req = 1; tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h66) begin
      errors++; $display("FAIL discard_next: vld=%b data=%h, required 1 66", rd_valid, rd_data);
    end
    xfer_done = 1; tick();
  endtask

  task automatic test_underflow();
    rd_req = 1; tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00 || underflow !== 1'b1) begin
      errors++; $display("FAIL underflow_set: vld=%b data=%h unf=%b, required 1 00 1", rd_valid, rd_data, underflow);
    end
    clr_flags = 1; tick();
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: unf=%b, required 0", underflow); end
    clr_flags = 1; rd_req = 1; tick();
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set_wins: unf=%b, required 1", underflow); end
    clr_flags = 1; tick();
  endtask

  task automatic test_full_simul();
    msb_first = 0;
    for (int i = 0; i < 4; i++) push_word(24'h100000 + 24'(i));
    rd_req = 1; tick();
    rd_req = 1; tick();
    wr_data = 24'hABCDEF; wr_en = 1; rd_req = 1; tick();
    checks++;
    if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0 || rd_data !== 8'h10) begin
      errors++; $display("FAIL full_simul: lvl=%0d full=%b ovf=%b data=%h, required 4 1 0 10", level, full, overflow, rd_data);
    end
  endtask

  task automatic test_reset_midword();
    rd_req = 1; tick();
    rst_n = 0;
    model_reset();
    #2;
    checks++;
    if (level !== 3'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_mid: lvl=%0d empty=%b vld=%b data=%h, required 0 1 0 00", level, empty, rd_valid, rd_data);
    end
    rst_n = 1;
    msb_first = 0;
    push_word(24'hA1B2C3);
    rd_req = 1; tick();
    checks++;
    if (rd_data !== 8'hC3) begin errors++; $display("FAIL reset_mid_byte0: data=%h, required c3", rd_data); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      wr_en        = ($urandom_range(0, 99) < 35);
      wr_data      = 24'($urandom);
      rd_req       = ($urandom_range(0, 99) < 55);
      xfer_done    = ($urandom_range(0, 99) < 6);
      clr_flags    = ($urandom_range(0, 99) < 5);
      keep_partial = $urandom_range(0, 1) == 1;
      msb_first    = $urandom_range(0, 1) == 1;
      tick();
      checks++;
      if ({rd_valid, rd_data, level, empty, full, overflow, underflow} !==
          {m_vld, m_dat, 3'(m_q.size()), m_q.size() == 0, m_q.size() == DP, m_ovf, m_unf}) begin
        errors++;
        $display("FAIL random_cycle%0d: vld=%b data=%h lvl=%0d e=%b f=%b o=%b u=%b, required %b %h %0d %b %b %b %b",
                 c, rd_valid, rd_data, level, empty, full, overflow, underflow,
                 m_vld, m_dat, m_q.size(), m_q.size() == 0, m_q.size() == DP, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_order_latch();
    test_overflow();
    test_abort_keep();
    test_abort_discard();
    test_underflow();
    test_full_simul();
    test_reset_midword();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/meas_word_serializer.md
Name: meas_word_serializer

Overview:
Parametrised measurement FIFO with byte-serial readout for the SPI control path. Counter words (BYTE_NUM bytes each) are written from the count prebuffer and streamed out one byte per read request from main_ctrl. Adds over the current fixed 24-bit/3-byte readout:
- generic word width and FIFO depth;
- selectable byte order;
- defined handling of an aborted SPI frame;
- exact level tracking with sticky overflow and underflow flags.

Parameters:
BYTE_NUM, 3, bytes per stored word (1..8); word width = 8*BYTE_NUM.
DEPTH, 16, FIFO depth in words; power of 2, minimum 2.
LVL_W, clog2(DEPTH)+1, localparam; width of the level output.

Ports:
clk_12mhz  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
wr_en  in  1  write strobe, one word per high cycle.
wr_data  in  8*BYTE_NUM  word to store.
rd_req  in  1  single-cycle pulse; requests the next byte.
xfer_done  in  1  single-cycle pulse; SPI frame ended.
msb_first  in  1  1 = most significant byte first, 0 = LSB first.
keep_partial  in  1  partially read word on abort: 1 = retain, 0 = discard.
clr_flags  in  1  clears overflow and underflow.
rd_data  out  8  byte output, registered.
rd_valid  out  1  one-cycle pulse: rd_data updated.
level  out  LVL_W  complete words stored (0..DEPTH).
empty  out  1  level == 0.
full  out  1  level == DEPTH.
overflow  out  1  sticky: a write was dropped.
underflow  out  1  sticky: a read was made while empty.

Behaviour:
Reset (rst_n low, asynchronous):
- all outputs 0 except empty = 1;
- pointers and byte_idx = 0; storage contents don't-care.

Write:
- wr_en && !full: store word at wr_ptr; wr_ptr wraps modulo DEPTH.
- wr_en && full: word dropped, overflow <= 1.
- Exception: a write while full in the same cycle as a word pop is accepted.

Read:
- byte_idx (0..BYTE_NUM-1) selects the byte within the head word.
- At byte_idx == 0 the msb_first value is latched and held until that word completes or is aborted.
- rd_req with a word present: next cycle rd_valid = 1 and rd_data = selected byte.
  - Order LSB-first: byte k = wr_data[8k+7:8k].
  - Order MSB-first: byte k = wr_data[8(BYTE_NUM-1-k)+7 : 8(BYTE_NUM-1-k)].
  - Latency is exactly 1 cycle.
- byte_idx increments per rd_req. On the last byte: byte_idx <= 0, rd_ptr advances, level decrements.
- rd_req while empty: rd_valid = 1, rd_data = 8'h00, underflow <= 1, no state change.
- A word written in the same cycle as rd_req is not bypassed; the read sees the pre-write state.
- rd_data holds its value while rd_valid = 0.

Abort (xfer_done):
- byte_idx == 0: no effect.
- byte_idx != 0 and keep_partial = 1: byte_idx <= 0; the word stays at the head and is re-sent from byte 0.
- byte_idx != 0 and keep_partial = 0: the head word is popped (rd_ptr+1, level-1) and byte_idx <= 0.
- xfer_done has priority over rd_req in the same cycle; that rd_req is ignored and rd_valid stays 0.

Level and flags:
- Same-cycle accepted write and pop: level unchanged.
- level never exceeds DEPTH and never wraps below 0.
- clr_flags clears both sticky flags. A set event in the same cycle wins over the clear.

Decomposition:
- Package meas_fifo_pkg:
  - BYTE_W = 8;
  - constant function clog2;
  - RD_EMPTY_BYTE = 8'h00.
- Sub-module meas_fifo_ram:
  - DEPTH x (8*BYTE_NUM) register array;
  - wr_ptr/rd_ptr with wrap, level counter, full/empty;
  - inputs push/pop; asynchronous read of the head word.
- The top of the block holds the byte_idx state, order latch, abort logic, output register and flags.

Test Plan (BYTE_NUM=3, DEPTH=4 unless noted):
- Write 0xA1B2C3, msb_first=0, 3 rd_req pulses -> rd_data C3, B2, A1, each 1 cycle after its request; level 1->0; empty=1.
- Write 0xA1B2C3, msb_first=1 at the first rd_req, toggle msb_first to 0 after the first byte -> bytes A1, B2, C3 (order latched).
- Write 5 words 0x000001..0x000005 -> level=4, full=1, overflow=1; read 12 bytes -> words 1..4 only.
- Write 0x112233 and 0x445566; send 1 byte (0x33), then xfer_done:
  - keep_partial=1 -> next 3 reads return 33, 22, 11;
  - keep_partial=0 -> next read returns 66 and level=1.
- rd_req while empty -> rd_valid=1, rd_data=00, underflow=1; clr_flags -> 0. clr_flags in the same cycle as an empty read -> underflow stays 1.
- Full FIFO, with wr_en and the last-byte rd_req in the same cycle -> write accepted, level stays 4, no overflow. Assert rst_n low mid-word -> level=0, empty=1; next word read from byte 0.
